// File: rtl/param_ntt_pkg.sv
// NTT datapath geometry shared by the NTT core blocks.
package param_ntt_pkg;
  localparam int unsigned PSI       = 1;
  localparam int unsigned R         = 2;
  localparam int unsigned MOD_NTT_W = 64;
endpackage

// File: rtl/param_tfhe_pkg.sv
// TFHE scheme parameters shared by the NTT core blocks.
package param_tfhe_pkg;
  localparam int unsigned GLWE_K_P1 = 2;
endpackage

// File: rtl/ntt_core_gf64_bsk_feeder.sv
// BSK feeder: splits each BSK word into independent per-(p,r,k) FIFOs toward the GF64 post-process.
// Define NTT_CORE_GF64_BSK_FEEDER_SKEW_EN to delay coef k by k cycles before its FIFO write.
module ntt_core_gf64_bsk_feeder #(
  parameter int unsigned PSI       = param_ntt_pkg::PSI,
  parameter int unsigned R         = param_ntt_pkg::R,
  parameter int unsigned GLWE_K_P1 = param_tfhe_pkg::GLWE_K_P1,
  parameter int unsigned MOD_NTT_W = param_ntt_pkg::MOD_NTT_W,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                                                    clk,
  input  logic                                                    s_rst_n,
  input  logic [PSI*R*GLWE_K_P1*MOD_NTT_W-1:0]                    in_bsk,
  input  logic                                                    in_vld,
  output logic                                                    in_rdy,
  output logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0][MOD_NTT_W-1:0]     bsk,
  output logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0]                    bsk_vld,
  input  logic [PSI-1:0][R-1:0][GLWE_K_P1-1:0]                    bsk_rdy,
  output logic                                                    error
);
  localparam int unsigned K     = GLWE_K_P1;
  localparam int unsigned W     = MOD_NTT_W;
  localparam int unsigned PR    = PSI * R;
  localparam int unsigned NC    = PR * K;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic                  w_xfer;
  logic [NC-1:0]         w_wr_en;
  logic [NC-1:0]         w_pop;
  logic [NC-1:0]         w_res_ok;
  logic [NC-1:0]         w_err_d;
  logic [NC-1:0]         w_rdy;
  logic [NC-1:0]         w_vld;
  logic [NC-1:0][W-1:0]  w_in;
  logic [NC-1:0][W-1:0]  w_wr_dat;
  logic [NC-1:0][W-1:0]  w_head;
  logic                  r_error;

  // Column index is (p*R + r)*K + k, identical to the packed layout of in_bsk and bsk.
  assign w_in    = in_bsk;
  assign w_rdy   = bsk_rdy;
  assign bsk_vld = w_vld;
  assign bsk     = w_head;
  assign in_rdy  = s_rst_n & (&w_res_ok);
  assign w_xfer  = in_vld & in_rdy;
  assign error   = r_error;

  genvar gk, gpr, gc;
  for (gk = 0; gk < K; gk++) begin : g_coef
    logic                  w_k_vld;
    logic [PR-1:0][W-1:0]  w_k_in;
    logic [PR-1:0][W-1:0]  w_k_dat;

    for (gpr = 0; gpr < PR; gpr++) begin : g_lane
      assign w_k_in[gpr]            = w_in[gpr*K + gk];
      assign w_wr_en[gpr*K + gk]    = w_k_vld;
      assign w_wr_dat[gpr*K + gk]   = w_k_dat[gpr];
    end

`ifdef NTT_CORE_GF64_BSK_FEEDER_SKEW_EN
    if (gk == 0) begin : g_nodly
      assign w_k_vld = w_xfer;
      assign w_k_dat = w_k_in;
    end else begin : g_dly
      logic [gk-1:0]                  r_pv;
      logic [gk-1:0][PR-1:0][W-1:0]   r_pd;

      always_ff @(posedge clk) begin
        if (!s_rst_n) begin
          r_pv <= '0;
        end else begin
          r_pv[0] <= w_xfer;
          for (int unsigned s = 1; s < gk; s++) r_pv[s] <= r_pv[s-1];
        end
      end

      always_ff @(posedge clk) begin
        r_pd[0] <= w_k_in;
        for (int unsigned s = 1; s < gk; s++) r_pd[s] <= r_pd[s-1];
      end

      assign w_k_vld = r_pv[gk-1];
      assign w_k_dat = r_pd[gk-1];
    end
`else
    assign w_k_vld = w_xfer;
    assign w_k_dat = w_k_in;
`endif
  end

  for (gc = 0; gc < NC; gc++) begin : g_col
    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PTR_W-1:0]        r_wp;
    logic [PTR_W-1:0]        r_rp;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_res;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_wr_ok;

    assign w_empty      = (r_cnt == '0);
    assign w_full       = (r_cnt == CNT_FULL);
    assign w_vld[gc]    = !w_empty;
    assign w_head[gc]   = r_mem[r_rp];
    assign w_pop[gc]    = !w_empty & w_rdy[gc];
    assign w_res_ok[gc] = (r_res < CNT_FULL);
    // An overflowing write is dropped so the count never exceeds DEPTH; it only raises error.
    assign w_wr_ok      = w_wr_en[gc] & (!w_full | w_pop[gc]);
    assign w_err_d[gc]  = (w_wr_en[gc] & w_full & !w_pop[gc]) | (w_pop[gc] & w_empty);

    always_ff @(posedge clk) begin
      if (!s_rst_n) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_res <= '0;
      end else begin
        if (w_wr_ok)   r_wp <= (r_wp == PTR_LAST) ? '0 : r_wp + 1'b1;
        if (w_pop[gc]) r_rp <= (r_rp == PTR_LAST) ? '0 : r_rp + 1'b1;

        if (w_wr_ok && !w_pop[gc])      r_cnt <= r_cnt + 1'b1;
        else if (!w_wr_ok && w_pop[gc]) r_cnt <= r_cnt - 1'b1;

        if (w_xfer && !w_pop[gc])       r_res <= r_res + 1'b1;
        else if (!w_xfer && w_pop[gc])  r_res <= r_res - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[r_wp] <= w_wr_dat[gc];
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) r_error <= 1'b0;
    else          r_error <= |w_err_d;
  end

endmodule

// File: tb/tb_ntt_core_gf64_bsk_feeder.sv
// Directed + randomized bench for ntt_core_gf64_bsk_feeder against a per-column queue model.
module tb_ntt_core_gf64_bsk_feeder;
  localparam int unsigned PSI   = 1;
  localparam int unsigned R     = 2;
  localparam int unsigned K     = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 64;
  localparam int unsigned NC    = PSI * R * K;
  localparam int unsigned CW    = $clog2(NC);
`ifdef NTT_CORE_GF64_BSK_FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                 s_rst_n;
  logic [NC*W-1:0]                      in_bsk;
  logic                                 in_vld;
  logic                                 in_rdy;
  logic [PSI-1:0][R-1:0][K-1:0][W-1:0]  bsk;
  logic [PSI-1:0][R-1:0][K-1:0]         bsk_vld;
  logic [PSI-1:0][R-1:0][K-1:0]         bsk_rdy;
  logic                                 error;

  ntt_core_gf64_bsk_feeder #(
    .PSI(PSI), .R(R), .GLWE_K_P1(K), .MOD_NTT_W(W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .s_rst_n(s_rst_n), .in_bsk(in_bsk), .in_vld(in_vld), .in_rdy(in_rdy),
    .bsk(bsk), .bsk_vld(bsk_vld), .bsk_rdy(bsk_rdy), .error(error)
  );

  logic [NC-1:0][W-1:0] bsk_f;
  logic [NC-1:0]        vld_f;
  assign bsk_f = bsk;
  assign vld_f = bsk_vld;

  // Reference: per column, queued words with the cycle from which each becomes visible.
  logic [W-1:0] qd [NC][$];
  int           qv [NC][$];

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  prev_rst = 1'b0;
  bit  last_xfer;
  logic                                 obs_rdy;
  logic [NC-1:0]                        obs_vld;
  logic [PSI-1:0][R-1:0][K-1:0][W-1:0]  obs_bsk;
  logic [NC-1:0][W-1:0]                 last_d;
  logic [NC-1:0][W-1:0]                 d0;

  function automatic int lat(int c);
    return SKEW ? (c % K) : 0;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit rst_n, input bit vld, input logic [NC-1:0] rdy);
    logic [NC-1:0] exp_vld;
    bit            exp_rdy;
    @(negedge clk);
    for (int c = 0; c < NC; c++) last_d[CW'(c)] = {$urandom, $urandom};
    s_rst_n = rst_n;
    in_vld  = vld;
    bsk_rdy = rdy;
    in_bsk  = last_d;
    #1;
    obs_rdy = in_rdy;
    obs_vld = vld_f;
    obs_bsk = bsk;
    last_xfer = 1'b0;
    if (!rst_n) begin
      chk("rst_in_rdy", in_rdy, 0);
      if (prev_rst) begin
        chk("rst_bsk_vld", vld_f, 0);
        chk("rst_error", error, 0);
      end
      for (int c = 0; c < NC; c++) begin
        qd[CW'(c)].delete();
        qv[CW'(c)].delete();
      end
    end else begin
      exp_rdy = 1'b1;
      for (int c = 0; c < NC; c++) if (qd[CW'(c)].size() >= DEPTH) exp_rdy = 1'b0;
      chk("in_rdy", in_rdy, exp_rdy);
      for (int c = 0; c < NC; c++) begin
        automatic logic [CW-1:0] ci = CW'(c);
        exp_vld[ci] = (qd[ci].size() > 0) && (qv[ci][0] <= cyc);
        chk($sformatf("bsk_vld[%0d]", c), vld_f[ci], exp_vld[ci]);
        if (exp_vld[ci]) chk($sformatf("bsk_dat[%0d]", c), bsk_f[ci], qd[ci][0]);
      end
      chk("error", error, 0);
      for (int c = 0; c < NC; c++) begin
        automatic logic [CW-1:0] ci = CW'(c);
        if (exp_vld[ci] && rdy[ci]) begin
          void'(qd[ci].pop_front());
          void'(qv[ci].pop_front());
        end
      end
      last_xfer = vld && exp_rdy;
      if (last_xfer) begin
        for (int c = 0; c < NC; c++) begin
          qd[CW'(c)].push_back(last_d[CW'(c)]);
          qv[CW'(c)].push_back(cyc + 1 + lat(c));
        end
      end
    end
    prev_rst = !rst_n;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int guard;
    s_rst_n = 1'b0;
    in_vld  = 1'b0;
    bsk_rdy = '0;
    in_bsk  = '0;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '1);
    while (cyc < 10) step(1'b1, 1'b0, '1);

    // Single word with ready everywhere
    step(1'b1, 1'b1, '1);
    d0 = last_d;
    chk("single_xfer", last_xfer, 1);
    for (int i = 1; i <= 2; i++) begin
      step(1'b1, 1'b0, '1);
      chk($sformatf("single_vld_t+%0d", i), obs_vld,
          (i == 1) ? (SKEW ? 4'b0101 : 4'b1111) : (SKEW ? 4'b1010 : 4'b0000));
      if (obs_vld[2]) chk("single_dat_r1k0", obs_bsk[0][1][0], d0[2]);
      if (obs_vld[3]) chk("single_dat_r1k1", obs_bsk[0][1][1], d0[3]);
    end
    step(1'b1, 1'b0, '1);
    chk("single_vld_end", obs_vld, 0);

    // Backpressure until every column is reserved full
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, '0);
      if (last_xfer) n++;
    end
    chk("bp_xfers", n, DEPTH);
    chk("bp_rdy_low", obs_rdy, 0);
    step(1'b1, 1'b1, 4'b0001);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, '0);
      chk("bp_rdy_hold", obs_rdy, 0);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '1);
    chk("bp_drained", obs_vld, 0);

    // Pop only column (0,1,1)
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, '0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1000);
    step(1'b1, 1'b0, '0);
    chk("ind_vld", obs_vld, 4'b0111);
    chk("ind_rdy", obs_rdy, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '1);
    chk("ind_drained", obs_vld, 0);

    // Random traffic across pointer wrap
    n = 0;
    guard = 0;
    while (n < 20 && guard < 400) begin
      step(1'b1, 1'($urandom_range(1, 0)), NC'($urandom));
      if (last_xfer) n++;
      guard++;
    end
    chk("wrap_words", n, 20);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '1);
    chk("wrap_drained", obs_vld, 0);

    // Reset with coef1 still in flight
    step(1'b1, 1'b1, '0);
    chk("rst_mid_xfer", last_xfer, 1);
    step(1'b0, 1'b0, '1);
    step(1'b0, 1'b0, '1);
    step(1'b1, 1'b0, '1);
    chk("post_rst_rdy", obs_rdy, 1);
    chk("post_rst_vld", obs_vld, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '1);
      chk("post_rst_no_stale", obs_vld, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_core_gf64_bsk_feeder.md
NTT_CORE_GF64_BSK_FEEDER -- requirements
Module: ntt_core_gf64_bsk_feeder

Interface
REQ-001 SHALL have parameter PSI, default from param_ntt_pkg, number of PSI lanes.
REQ-002 SHALL have parameter R, default from param_ntt_pkg, radix lanes per PSI.
REQ-003 SHALL have parameter GLWE_K_P1, default from param_tfhe_pkg, BSK coefficients per datum (K below).
REQ-004 SHALL have parameter MOD_NTT_W, default from param_ntt_pkg, coefficient width.
REQ-005 SHALL have parameter DEPTH, default 4, per-column FIFO depth; legal DEPTH >= 2.
REQ-006 SHALL have clk  input  1  clock.
REQ-007 SHALL have s_rst_n  input  1  reset; synchronous, active-low.
REQ-008 SHALL have in_bsk  input  PSI*R*K*MOD_NTT_W  BSK word from the BSK manager, all lanes and coefs.
REQ-009 SHALL have in_vld  input  1  in_bsk valid.
REQ-010 SHALL have in_rdy  output  1  feeder accepts in_bsk.
REQ-011 SHALL have bsk  output  [PSI][R][K][MOD_NTT_W]  coefficient toward the GF64 post-process.
REQ-012 SHALL have bsk_vld  output  [PSI][R][K]  per-coefficient valid.
REQ-013 SHALL have bsk_rdy  input  [PSI][R][K]  per-coefficient ready from the post-process.
REQ-014 SHALL have error  output  1  registered overflow/underflow flag.

Function
REQ-015 SHALL implement one independent FIFO of DEPTH entries per column (p,r,k).
REQ-016 SHALL accept the input word on a cycle where in_vld=1 and in_rdy=1 (transfer).
REQ-017 SHALL keep a reserved counter per column, 0..DEPTH, +1 on transfer, -1 on pop (bsk_vld & bsk_rdy). Both on the same cycle leave it unchanged.
REQ-018 SHALL drive in_rdy = 1 only when every column reserved counter < DEPTH. There is no same-cycle pop bypass.
REQ-019 SHALL route coef k of a transferred word through a k-stage delay pipe (data plus valid bit, no backpressure) before writing it into column k FIFO. With transfer at cycle t, the coef k write occurs at edge t+k.
REQ-020 SHALL drive bsk_vld[p][r][k] = column FIFO non-empty, and bsk = FIFO head, registered. Coef k is first visible in cycle t+1+k, giving the 1-cycle-per-coef skew expected by the consumer.
REQ-021 SHALL let each column pop independently of the other columns and lanes. Per-column order is strictly FIFO.
REQ-022 SHALL, because reservation counts in-flight pipe entries, never write a full FIFO. A write to a full FIFO or a pop of an empty FIFO sets errorD.
REQ-023 SHALL register error = OR of all column errorD, one cycle after the event. It is a pulse, not sticky.
REQ-024 SHALL make full/empty wrap-around of the FIFO pointers modulo DEPTH, with count-based full/empty detection (no lost slot).
REQ-025 SHALL not modify data: coefficient bits pass unaltered, with no modular reduction.

Reset
REQ-026 SHALL, while s_rst_n=0: clear all reserved counters, FIFO counts, pointers and delay-pipe valid bits; drive bsk_vld=0, in_rdy=0, error=0. bsk data is don't-care.
REQ-027 SHALL drop in-flight pipe data on reset mid-operation. The first post-reset cycle has in_rdy=1 and bsk_vld=0.

Configuration
REQ-028 SHALL support macro NTT_CORE_GF64_BSK_FEEDER_SKEW_EN.
REQ-029 SHALL, with NTT_CORE_GF64_BSK_FEEDER_SKEW_EN defined, implement the k-stage skew pipes of REQ-019.
REQ-030 SHALL, with NTT_CORE_GF64_BSK_FEEDER_SKEW_EN undefined, omit the skew pipes. All coefs are written at edge t and all are visible at t+1. All other requirements are unchanged.

Verification (PSI=1, R=2, K=2, DEPTH=4, MOD_NTT_W=64, skew enabled)
REQ-031 SHALL check single word: transfer at cycle 10, bsk_rdy all 1 -> coef0 vld cycles 11 on both r, coef1 vld cycle 12, data equal to input, error=0.
REQ-032 SHALL check backpressure full: bsk_rdy all 0, in_vld=1 constant -> exactly 4 transfers, then in_rdy=0. Release bsk_rdy[0][0][0] for one cycle -> in_rdy stays 0 (other columns full).
REQ-033 SHALL check independent pop: 3 words queued, pop only column (0,1,1) 3 times -> that column empties in order, others keep 3 entries, in_rdy=0 until all columns have reserved<4.
REQ-034 SHALL check wrap-around: 20 words with random bsk_rdy (50%) -> per-column output sequence equals input sequence, error never asserts.
REQ-035 SHALL check reset mid-op: assert s_rst_n=0 one cycle after a transfer (coef1 still in pipe) -> after release bsk_vld=0 everywhere, in_rdy=1, no stale coef1 ever emitted.
REQ-036 SHALL check skew disabled build: transfer at cycle 10 -> coef0 and coef1 both vld at cycle 11.
